// File: rtl/data_sram_slave_pkg.sv
// Shared types and helpers for the data-side SRAM responder and its request queue.
package data_sram_slave_pkg;

   typedef enum logic [1:0] {
      SzByte = 2'd0,
      SzHalf = 2'd1,
      SzWord = 2'd2
   } sram_size_e;

   typedef struct packed {
      logic        wr;
      logic [31:0] data;
   } q_entry_t;

   localparam int unsigned QEntryW = $bits(q_entry_t);

   function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

   // 16-bit Fibonacci LFSR, taps 16,14,13,11.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/data_sram_slave_req_queue.sv
// In-order circular queue of accepted requests; each slot ages until LAT-1 and the
// head is reported ready once it has aged out.
module data_sram_slave_req_queue
   import data_sram_slave_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LAT   = 1
) (
   input  logic     clk,
   input  logic     resetn,
   input  logic     push,
   input  q_entry_t push_entry,
   input  logic     pop,
   output logic     full,
   output logic     head_ready,
   output q_entry_t head_entry
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned AgeW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [AgeW-1:0] AgeMax = AgeW'(LAT - 1);

   q_entry_t        entry_q [DEPTH];
   logic [AgeW-1:0] age_q   [DEPTH];
   logic [PtrW-1:0] head_q, tail_q;
   logic [CntW-1:0] count_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
            age_q[i]   <= '0;
         end
      end else begin
         // Free slots age too; push restarts the age, so stale values never matter.
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (tail_q == PtrW'(i))) begin
               entry_q[i] <= push_entry;
               age_q[i]   <= '0;
            end else if (age_q[i] != AgeMax) begin
               age_q[i] <= age_q[i] + 1'b1;
            end
         end
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

   assign full       = (count_q == CntW'(DEPTH));
   assign head_ready = (count_q != '0) && (age_q[head_q] == AgeMax);
   assign head_entry = entry_q[head_q];

endmodule

// File: rtl/data_sram_slave.sv
// Responder for the CPU data-side SRAM-like interface: word RAM, in-order response
// queue with fixed latency, optional LFSR throttling of addr_ok.
module data_sram_slave
   import data_sram_slave_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned LAT       = 1,
   parameter bit          RAND_EN   = 1'b0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] idx;
   logic [15:0]       lfsr_q;
   logic              full;
   logic              head_ready;
   q_entry_t          push_entry;
   q_entry_t          head_entry;
   logic              unused_bits;

   assign idx         = addr[ADDR_W+1:2];
   assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= lfsr_step(lfsr_q);
   end

   assign addr_ok = resetn && req && !full && (!RAND_EN || lfsr_q[0]);

   // Contents survive reset; acceptance already implies resetn is high.
   always_ff @(posedge clk) begin
      if (addr_ok && wr) mem[idx] <= strb_merge(mem[idx], wdata, wstrb);
   end

   always_comb begin
      push_entry      = '0;
      push_entry.wr   = wr;
      push_entry.data = wr ? 32'h0 : mem[idx];
   end

   data_sram_slave_req_queue #(
      .DEPTH (DEPTH),
      .LAT   (LAT)
   ) u_req_queue (
      .clk        (clk),
      .resetn     (resetn),
      .push       (addr_ok),
      .push_entry (push_entry),
      .pop        (data_ok),
      .full       (full),
      .head_ready (head_ready),
      .head_entry (head_entry)
   );

   assign data_ok = head_ready;
   assign rdata   = (data_ok && !head_entry.wr) ? head_entry.data : 32'h0;

endmodule

// File: tb/tb_data_sram_slave.sv
// Randomized scoreboard bench for data_sram_slave with a throttled, long-latency config.
module tb_data_sram_slave;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned LAT    = 5;
   localparam logic [15:0] SEED   = 16'hACE1;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic        req    = 1'b0;
   logic        wr     = 1'b0;
   logic [1:0]  size   = 2'd2;
   logic [3:0]  wstrb  = 4'h0;
   logic [31:0] addr   = 32'h0;
   logic [31:0] wdata  = 32'h0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   data_sram_slave #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .LAT       (LAT),
      .RAND_EN   (1'b1),
      .LFSR_SEED (SEED)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .req     (req),
      .wr      (wr),
      .size    (size),
      .wstrb   (wstrb),
      .addr    (addr),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata)
   );

   typedef struct {
      logic [31:0] data;
      logic [31:0] mask;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          due_q[$];
   logic [31:0] mem_m   [1 << ADDR_W];
   logic [3:0]  known_m [1 << ADDR_W];
   logic [15:0] lfsr_m      = SEED;
   logic        exp_addr_ok = 1'b0;
   int          cyc      = 0;
   int          last_due = 0;
   int          n_pass   = 0;
   int          n_total  = 0;
   exp_t        mon_e;

   function automatic logic [15:0] lfsr_model(input logic [15:0] s);
      int fb;
      fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
      return 16'(((s << 1) | fb) & 16'hFFFF);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
   endtask

   // Apply the request presented before this edge to the model and queue its response.
   task automatic accept_model();
      int   idx;
      exp_t e;
      idx   = int'((addr >> 2) & ((1 << ADDR_W) - 1));
      e.due = (cyc + LAT - 1 > last_due) ? cyc + LAT - 1 : last_due + 1;
      last_due = e.due;
      due_q.push_back(e.due);
      if (wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
               known_m[idx][b]      = 1'b1;
            end
         end
         e.data = 32'h0;
         e.mask = 32'hFFFF_FFFF;
      end else begin
         e.data = mem_m[idx];
         for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{known_m[idx][b]}};
      end
      sb.push_back(e);
   endtask

   task automatic step(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      @(posedge clk);
      cyc++;
      if (exp_addr_ok) accept_model();
      lfsr_m = lfsr_model(lfsr_m);
      while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
      #1;
      req   = r;
      wr    = w;
      addr  = a;
      wdata = d;
      wstrb = s;
      exp_addr_ok = r && (due_q.size() < DEPTH) && lfsr_m[0];
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      int n;
      n = 0;
      do begin
         step(1'b1, w, a, d, s);
         n++;
      end while (!exp_addr_ok && n < 200);
      if (!exp_addr_ok) begin
         n_total++;
         $display("FAIL issue_timeout: addr %h never accepted by model", a);
      end
   endtask

   task automatic do_reset();
      #1 resetn = 1'b0;
      #1;
      check("rst_now_addr_ok", {31'h0, addr_ok}, 32'h0);
      check("rst_now_data_ok", {31'h0, data_ok}, 32'h0);
      check("rst_now_rdata", rdata, 32'h0);
      sb.delete();
      due_q.delete();
      req         = 1'b0;
      exp_addr_ok = 1'b0;
      last_due    = 0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      lfsr_m = SEED;
   endtask

   task automatic random_phase(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 9) < 7)
            issue(1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2)
                     | 32'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(0, 15)));
         else
            step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
   endtask

   always @(negedge clk) begin
      if (!resetn) begin
         check("rst_addr_ok", {31'h0, addr_ok}, 32'h0);
         check("rst_data_ok", {31'h0, data_ok}, 32'h0);
         check("rst_rdata", rdata, 32'h0);
      end else begin
         check("addr_ok", {31'h0, addr_ok}, {31'h0, exp_addr_ok});
         if (data_ok) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL spurious_data_ok: got data_ok=1, want 0 (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               check("resp_cycle", cyc, mon_e.due);
               check("rdata", rdata & mon_e.mask, mon_e.data & mon_e.mask);
            end
         end else begin
            check("rdata_idle", rdata, 32'h0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
               n_total++;
               $display("FAIL missing_data_ok: got data_ok=0, want 1 (cycle %0d)", cyc);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) known_m[i] = 4'h0;
      req = 1'b1;
      repeat (3) @(posedge clk);
      #1 req = 1'b0;
      resetn = 1'b1;
      lfsr_m = SEED;

      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      issue(1'b1, 32'h10, 32'h1122_3344, 4'hF);
      issue(1'b1, 32'h12, 32'h00AB_0000, 4'b0100);
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) issue(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
      for (int i = 0; i < 5; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
      issue(1'b1, 32'h20, 32'h55, 4'hF);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      issue(1'b1, 32'hABCD_0123, 32'h0000_0077, 4'b0001);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      issue(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0);
      issue(1'b0, 32'h20, 32'h0, 4'h0);

      random_phase(300);

      issue(1'b0, 32'h20, 32'h0, 4'h0);
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      do_reset();
      repeat (8) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      issue(1'b0, 32'h10, 32'h0, 4'h0);

      random_phase(200);

      repeat (DEPTH * LAT + 8) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
